// File: rtl/game_progress_counter.sv
// Snake game progress: apple score, timed-mode countdown and win flags.
// Counts in PLAY, clears in START, freezes in WINNER/LOSER.
module game_progress_counter #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int TARGET_SCORE = 10,
  parameter int TIME_LIMIT_S = 60
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] MSM_STATE,
  input  logic       TIMED_MODE,
  input  logic       APPLE_EATEN,
  output logic [7:0] SCORE_BCD,
  output logic [7:0] TIME_LEFT_BCD,
  output logic       SCORE_WIN,
  output logic       WIN
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_WINNER = 2'd2,
    ST_LOSER  = 2'd3
  } msm_e;

  localparam int PW = $clog2(CLK_FREQ);

  localparam logic [7:0] TIME_INIT =
    8'(((TIME_LIMIT_S / 10) << 4) + (TIME_LIMIT_S % 10));
  localparam logic [7:0] TARGET_BCD =
    8'(((TARGET_SCORE / 10) << 4) + (TARGET_SCORE % 10));
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  msm_e          msm;
  logic          apple_q;
  logic          timed_q;
  logic [PW-1:0] presc;
  logic [7:0]    score;
  logic [7:0]    tleft;
  logic          swin;
  logic          win;

  logic          rise;
  logic          wrap;
  logic          timed_n;
  logic [PW-1:0] presc_n;
  logic [7:0]    score_n;
  logic [7:0]    tleft_n;
  logic          swin_n;
  logic          win_n;

  assign msm  = msm_e'(MSM_STATE);
  assign rise = APPLE_EATEN & ~apple_q;
  assign wrap = (presc == PRESC_MAX);

  // Next-state for score, countdown, prescaler and win flags
  always_comb begin
    timed_n = timed_q;
    presc_n = presc;
    score_n = score;
    tleft_n = tleft;
    swin_n  = swin;
    win_n   = win;
    unique case (msm)
      ST_START: begin
        timed_n = TIMED_MODE;
        presc_n = '0;
        score_n = 8'h00;
        tleft_n = TIME_INIT;
        swin_n  = 1'b0;
        win_n   = 1'b0;
      end
      ST_PLAY: begin
        if (rise && score != 8'h99) begin
          if (score[3:0] == 4'd9)
            score_n = {score[7:4] + 4'd1, 4'd0};
          else
            score_n = {score[7:4], score[3:0] + 4'd1};
        end
        if (timed_q) begin
          presc_n = wrap ? '0 : presc + 1'b1;
          if (wrap && tleft != 8'h00) begin
            if (tleft[3:0] == 4'd0)
              tleft_n = {tleft[7:4] - 4'd1, 4'd9};
            else
              tleft_n = {tleft[7:4], tleft[3:0] - 4'd1};
          end
        end
        swin_n = (score_n >= TARGET_BCD);
        win_n  = timed_q && (tleft_n == 8'h00);
      end
      ST_WINNER, ST_LOSER: begin
      end
    endcase
  end

  // Apple edge detector runs in every state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) apple_q <= 1'b0;
    else       apple_q <= APPLE_EATEN;
  end

  // Game progress state registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      timed_q <= 1'b0;
      presc   <= '0;
      score   <= 8'h00;
      tleft   <= TIME_INIT;
      swin    <= 1'b0;
      win     <= 1'b0;
    end else begin
      timed_q <= timed_n;
      presc   <= presc_n;
      score   <= score_n;
      tleft   <= tleft_n;
      swin    <= swin_n;
      win     <= win_n;
    end
  end

  assign SCORE_BCD     = score;
  assign TIME_LEFT_BCD = tleft;
  assign SCORE_WIN     = swin;
  assign WIN           = win;

endmodule

// File: tb/tb_game_progress_counter.sv
// Bench for game_progress_counter: directed and random play sessions
// compared each cycle against an integer-level game model.
module tb_game_progress_counter;

  localparam int FREQ   = 4;
  localparam int TARGET = 10;
  localparam int LIMIT  = 3;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] MSM_STATE;
  logic       TIMED_MODE;
  logic       APPLE_EATEN;
  logic [7:0] SCORE_BCD;
  logic [7:0] TIME_LEFT_BCD;
  logic       SCORE_WIN;
  logic       WIN;

  int checks = 0;
  int fails  = 0;

  int m_score, m_ticks;
  bit m_timed, m_prev;

  game_progress_counter #(
    .CLK_FREQ    (FREQ),
    .TARGET_SCORE(TARGET),
    .TIME_LIMIT_S(LIMIT)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .MSM_STATE    (MSM_STATE),
    .TIMED_MODE   (TIMED_MODE),
    .APPLE_EATEN  (APPLE_EATEN),
    .SCORE_BCD    (SCORE_BCD),
    .TIME_LEFT_BCD(TIME_LEFT_BCD),
    .SCORE_WIN    (SCORE_WIN),
    .WIN          (WIN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  function automatic int secs_left();
    int t;
    t = LIMIT - m_ticks / FREQ;
    return (t < 0) ? 0 : t;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int t;
    t = secs_left();
    check({tag, " score"}, SCORE_BCD, bcd(m_score));
    check({tag, " time"}, TIME_LEFT_BCD, bcd(t));
    check({tag, " score_win"}, 8'(SCORE_WIN), 8'(m_score >= TARGET));
    check({tag, " win"}, 8'(WIN), 8'(m_timed && t == 0));
  endtask

  task automatic model_reset();
    m_score = 0;
    m_ticks = 0;
    m_timed = 1'b0;
    m_prev  = 1'b0;
  endtask

  task automatic step(input logic [1:0] st, input bit mode,
                      input bit apple, input string tag);
    bit rise;
    MSM_STATE   = st;
    TIMED_MODE  = mode;
    APPLE_EATEN = apple;
    @(posedge CLK);
    rise   = apple && !m_prev;
    m_prev = apple;
    if (st == 2'd0) begin
      m_score = 0;
      m_ticks = 0;
      m_timed = mode;
    end else if (st == 2'd1) begin
      if (rise && m_score < 99) m_score++;
      if (m_timed) m_ticks++;
    end
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET       = 1'b1;
    MSM_STATE   = 2'd0;
    TIMED_MODE  = 1'b0;
    APPLE_EATEN = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) step(2'd0, 1'b0, 1'b0, "start_idle");

    for (int i = 0; i < 10; i++) begin
      step(2'd1, 1'b0, 1'b1, "apple_pulse");
      step(2'd1, 1'b0, 1'b0, "apple_idle");
    end
    for (int i = 0; i < 5; i++) step(2'd1, 1'b0, 1'b1, "long_pulse");
    step(2'd1, 1'b0, 1'b0, "long_pulse_end");

    for (int i = 0; i < 100; i++) step(2'd1, 1'b1, 1'b0, "mode_latch");

    for (int i = 0; i < 120; i++) begin
      step(2'd1, 1'b0, 1'b1, "sat_hi");
      step(2'd1, 1'b0, 1'b0, "sat_lo");
    end
    for (int i = 0; i < 6; i++) step(2'd2, 1'b0, i[0], "frozen");
    step(2'd0, 1'b0, 1'b0, "clear");

    step(2'd0, 1'b1, 1'b0, "timed_start");
    for (int i = 1; i <= 12; i++)
      step(2'd1, 1'b0, (i == 12), "countdown");
    for (int i = 0; i < 8; i++) step(2'd1, 1'b0, 1'b0, "expired");
    for (int i = 0; i < 4; i++) step(2'd3, 1'b0, 1'b1, "loser_hold");

    step(2'd0, 1'b1, 1'b0, "rst_start");
    for (int i = 0; i < 6; i++) step(2'd1, 1'b1, i[0], "pre_rst");
    async_reset("mid_reset");
    step(2'd0, 1'b0, 1'b0, "post_reset");

    for (int i = 0; i < 3000; i++) begin
      logic [1:0] st;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3)       st = 2'd0;
      else if (r < 90) st = 2'd1;
      else             st = 2'(2 + (r & 1));
      if ($urandom_range(0, 499) == 0) async_reset("rand_reset");
      step(st, 1'($urandom), 1'($urandom), "random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/game_progress_counter.md
# game_progress_counter

Tracks apples eaten and the timed-mode countdown for the snake game, and produces the `SCORE_WIN` and `WIN` inputs consumed by `Master_state_machine`. It reads the master state `MSM_STATE` back from that machine. It counts only while the game is in PLAY, clears in START, and freezes in WINNER/LOSER. It also drives two-digit BCD score and time values for the seven-segment display.

## Interface
- `CLK_FREQ`, 100_000_000: CLK cycles per one-second countdown tick; must be ≥ 2.
- `TARGET_SCORE`, 10: score (1..99) at which `SCORE_WIN` asserts.
- `TIME_LIMIT_S`, 60: countdown start value in seconds (1..99).
- `CLK`  input  1: system clock; all state on rising edge.
- `RESET`  input  1: reset, asynchronous, active-high.
- `MSM_STATE`  input  2: master state; 0 START, 1 PLAY, 2 WINNER, 3 LOSER.
- `TIMED_MODE`  input  1: switch level; selects timed game; latched in START only.
- `APPLE_EATEN`  input  1: level from the snake/target logic; each rising edge scores one point.
- `SCORE_BCD`  output  8: score, [7:4] tens, [3:0] units, BCD.
- `TIME_LEFT_BCD`  output  8: seconds remaining, BCD.
- `SCORE_WIN`  output  1: registered; high while score ≥ `TARGET_SCORE`.
- `WIN`  output  1: registered; high while timed mode is latched and time left = 00.

## Operation
- Internal registers:
  - `apple_q`: previous `APPLE_EATEN`.
  - `timed_q`: latched mode.
  - `presc`: prescaler, ceil(log2(`CLK_FREQ`)) bits.
  - score BCD and time BCD registers.
- `apple_q` updates every cycle, in every state. A rise is `APPLE_EATEN & ~apple_q`.
- **START (0):**
  - score ← 00.
  - time ← `TIME_LIMIT_S` in BCD.
  - `presc` ← 0.
  - `timed_q` ← `TIMED_MODE`.
  - `SCORE_WIN` ← 0, `WIN` ← 0.
- **PLAY (1):**
  - On a rise, score increments by 1 in BCD. Units 9→0 carries into tens. The score saturates at 99; a rise at 99 leaves it at 99.
  - If `timed_q` = 1:
    - `presc` counts 0..`CLK_FREQ`-1, then wraps to 0.
    - On the wrap cycle (`presc` = `CLK_FREQ`-1), time decrements by 1 in BCD. Units 0→9 borrows from tens.
    - At time 00 there is no decrement; time holds at 00 and `presc` keeps running.
  - If `timed_q` = 0: `presc` and time hold.
- **WINNER (2) / LOSER (3):** score, time, `presc`, `timed_q` and both outputs hold. Rises are ignored.
- **Output update:**
  - `SCORE_WIN` is registered from the next-score value: it rises on the same edge the score register reaches `TARGET_SCORE`.
  - `WIN` is registered from the next-time value: it rises on the same edge time becomes 00, and only when `timed_q` = 1.
- A rise and a timer wrap in the same PLAY cycle are both applied. If both outputs assert together, `Master_state_machine` resolves priority; this block does none.
- `TIMED_MODE` changes outside START have no effect.
- Out-of-range parameters are not checked; behaviour for them is unspecified.

## Timing
- **Reset values:**
  - `SCORE_BCD` = 00.
  - `TIME_LEFT_BCD` = `TIME_LIMIT_S` BCD.
  - `SCORE_WIN` = 0, `WIN` = 0.
  - `apple_q` = 0, `timed_q` = 0, `presc` = 0.
- RESET mid-game asynchronously restores all reset values. No partial count survives.
- **Score latency:** `APPLE_EATEN` first sampled high at edge N (with `apple_q` = 0) → `SCORE_BCD` updated after edge N. `APPLE_EATEN` held high scores exactly once.
- **Countdown:**
  - First decrement occurs `CLK_FREQ` PLAY cycles after entering PLAY.
  - Subsequent decrements occur every `CLK_FREQ` PLAY cycles.
  - Prescaler progress is preserved across a PLAY→WINNER/LOSER freeze, but that progress is never resumed without passing through START.
- `SCORE_WIN` and `WIN` are stable levels, not pulses. They remain high through WINNER/LOSER until START or RESET.
- No combinational paths from inputs to outputs.

## Test plan
- **Reset:** apply RESET with `TIME_LIMIT_S`=60 → `SCORE_BCD`=0x00, `TIME_LEFT_BCD`=0x60, `SCORE_WIN`=0, `WIN`=0. Release RESET with `MSM_STATE`=0 → values unchanged.
- **Score to target:** `TARGET_SCORE`=10, `MSM_STATE`=1, 10 one-cycle `APPLE_EATEN` pulses separated by idle cycles → `SCORE_BCD` steps 0x01..0x09, then 0x10. `SCORE_WIN` rises on the same edge as 0x10. A 5-cycle-long pulse adds exactly 1.
- **Saturation / freeze:**
  - 120 rises in PLAY with `TARGET_SCORE`=99 → `SCORE_BCD`=0x99.
  - `MSM_STATE`=2 plus further rises → no change.
  - `MSM_STATE`=0 → 0x00 and `SCORE_WIN`=0 one edge later.
- **Timed countdown:** `CLK_FREQ`=4, `TIME_LIMIT_S`=3, `TIMED_MODE`=1 in START, then PLAY → `TIME_LEFT_BCD` 0x03→0x02→0x01→0x00 at cycles 4, 8 and 12. `WIN` rises with 0x00, then holds.
- **Mode latching:** `TIMED_MODE`=0 in START, set to 1 during PLAY → `TIME_LEFT_BCD` stays at `TIME_LIMIT_S`, `WIN`=0 for 100 cycles.
- **Simultaneous events / reset:**
  - Apple rise on the expiry cycle → score increments and `WIN` asserts on the same edge.
  - RESET asserted mid-count → immediate return to reset values.
